// File: rtl/full_adder_64.sv
// Registered WIDTH-bit ripple-carry adder: {CarryOut,Sum} = X + Y + CarryIn, one cycle latency.
// A generate loop chains 1-bit full-adder cells, and the output register follows the chain.
module full_adder_64 #(
    parameter int WIDTH = 64
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             CarryIn,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut
);

    // One full-adder cell; returns {carry_out, sum_bit}.
    function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic cin);
        logic p;
        p = a ^ b;
        return {(a & b) | (cin & p), p ^ cin};
    endfunction

    logic [WIDTH-1:0] sum_s;
    logic             carry_s;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_d;
    logic             carry_q;

    // Each cell keeps its carry locally so the chain is not one self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic cin_s;
        logic cout_s;
        logic s_s;

        if (i == 0) begin : g_first
            assign cin_s = CarryIn;
        end else begin : g_chain
            assign cin_s = g_cell[i-1].cout_s;
        end

        assign {cout_s, s_s} = fa_cell(X[i], Y[i], cin_s);
        assign sum_s[i]      = s_s;
    end

    assign carry_s = g_cell[WIDTH-1].cout_s;

    // Next-state of the output register: the ripple-chain result.
    always_comb begin
        sum_d   = sum_s;
        carry_d = carry_s;
    end

    // Output register; asynchronous clear discards any in-flight result.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign Sum      = sum_q;
    assign CarryOut = carry_q;

endmodule

// File: tb/tb_full_adder_64.sv
// Self-checking bench for full_adder_64: directed table, reset sequences and random back-to-back
// vectors on the default 64-bit instance and on an 8-bit override.
module tb_full_adder_64;

    logic        Clock;
    logic        Reset_n;
    logic [63:0] x;
    logic [63:0] y;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic [7:0]  x8;
    logic [7:0]  y8;
    logic        cin8;
    logic [7:0]  sum8;
    logic        cout8;

    int total = 0;
    int bad   = 0;

    full_adder_64 dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .X       (x),
        .Y       (y),
        .CarryIn (cin),
        .Sum     (sum),
        .CarryOut(cout)
    );

    full_adder_64 #(.WIDTH(8)) dut8 (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .X       (x8),
        .Y       (y8),
        .CarryIn (cin8),
        .Sum     (sum8),
        .CarryOut(cout8)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        ci;
        logic [63:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present operands on the falling edge, then sample 1 time unit after the next rising edge.
    task automatic apply64(input logic [63:0] a, input logic [63:0] b, input logic ci);
        @(negedge Clock);
        x   = a;
        y   = b;
        cin = ci;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [64:0] exp65;
        logic [8:0]  exp9;

        vecs[0] = '{"one_plus_one", 64'd1, 64'd1, 1'b0, 64'd2, 1'b0};
        vecs[1] = '{"231_698", 64'd231, 64'd698, 1'b0, 64'd929, 1'b0};
        vecs[2] = '{"cin_1e9", 64'd999999999, 64'd1, 1'b1, 64'd1000000001, 1'b0};
        vecs[3] = '{"msb_msb_cin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'd1, 1'b1};
        vecs[4] = '{"ones_zero_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1};
        vecs[5] = '{"ones_ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[6] = '{"zero", 64'd0, 64'd0, 1'b0, 64'd0, 1'b0};
        vecs[7] = '{"alt_bits", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

        Reset_n = 1'b0;
        x = 64'd5; y = 64'd7; cin = 1'b0;
        x8 = 8'd0; y8 = 8'd0; cin8 = 1'b0;
        #1;
        check("reset_sum_t0", sum, 64'd0);
        check("reset_cout_t0", {63'd0, cout}, 64'd0);

        // Clocking with operands while held in reset must keep outputs cleared.
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            #1;
            check("reset_hold_sum", sum, 64'd0);
            check("reset_hold_sum8", {56'd0, sum8}, 64'd0);
        end
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        check("release_sum12", sum, 64'd12);
        check("release_cout", {63'd0, cout}, 64'd0);

        foreach (vecs[i]) begin
            apply64(vecs[i].a, vecs[i].b, vecs[i].ci);
            check({vecs[i].name, "_sum"}, sum, vecs[i].exp_sum);
            check({vecs[i].name, "_cout"}, {63'd0, cout}, {63'd0, vecs[i].exp_cout});
        end

        // Asynchronous assertion clears outputs without waiting for a clock edge.
        apply64(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        @(negedge Clock);
        x = 64'd100; y = 64'd200; cin = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_rst_sum", sum, 64'd0);
        check("async_rst_cout", {63'd0, cout}, 64'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        x = 64'd40; y = 64'd2; cin = 1'b1;
        @(posedge Clock);
        #1;
        check("post_rst_first", sum, 64'd43);

        // 8-bit override wrap-around corners.
        @(negedge Clock);
        x8 = 8'hFF; y8 = 8'h00; cin8 = 1'b1;
        @(posedge Clock);
        #1;
        check("w8_ones_zero_sum", {56'd0, sum8}, 64'd0);
        check("w8_ones_zero_cout", {63'd0, cout8}, 64'd1);
        @(negedge Clock);
        x8 = 8'hFF; y8 = 8'hFF; cin8 = 1'b1;
        @(posedge Clock);
        #1;
        check("w8_ones_ones_sum", {56'd0, sum8}, 64'hFF);
        check("w8_ones_ones_cout", {63'd0, cout8}, 64'd1);

        // Back-to-back random operands, one new vector per cycle on both instances.
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clock);
            x    = {$urandom(), $urandom()};
            y    = {$urandom(), $urandom()};
            cin  = 1'($urandom_range(1, 0));
            x8   = 8'($urandom());
            y8   = 8'($urandom());
            cin8 = 1'($urandom_range(1, 0));
            if (i % 7 == 0) begin
                x = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            exp65 = {1'b0, x} + {1'b0, y} + {64'd0, cin};
            exp9  = {1'b0, x8} + {1'b0, y8} + {8'd0, cin8};
            @(posedge Clock);
            #1;
            check("rand_sum", sum, exp65[63:0]);
            check("rand_cout", {63'd0, cout}, {63'd0, exp65[64]});
            check("rand8_sum", {56'd0, sum8}, {56'd0, exp9[7:0]});
            check("rand8_cout", {63'd0, cout8}, {63'd0, exp9[8]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
